// File: rtl/jtag_tgt_master_if.sv
// Command/response bus of the target-side JTAG master.
// The requester drives commands through master; the JTAG engine uses slave.
interface jtag_tgt_master_if #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LENW    = 6
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [LENW-1:0]    cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_tgt_master.sv
// Command-driven JTAG master for the target TAP, sharing the pins with the
// UJTAG tunnel. The tunnel has priority whenever the master is idle.
module jtag_tgt_master #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LENW    = 6,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  jtag_tgt_master_if.slave cmd_if,
  input  logic             tun_req_i,
  input  logic             tun_tck_i,
  input  logic             tun_tms_i,
  input  logic             tun_tdi_i,
  input  logic             tun_trst_i,
  output logic             grant_tun_o,
  input  logic             tgt_tdo_i,
  output logic             tgt_tck_o,
  output logic             tgt_tms_o,
  output logic             tgt_tdi_o,
  output logic             tgt_trst_o
);

  localparam int unsigned SW = (LENW < 3) ? 3 : LENW;
  localparam int unsigned CW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    S_RESET_TAP,
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_UPD,
    S_RTI,
    S_RESP,
    S_OWN_TUN
  } state_e;

  state_e             state_q, state_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_q, trst_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      step_q, step_d;
  logic               is_ir_q, is_ir_d;
  logic [LENW-1:0]    len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic               ret_rsp_q, ret_rsp_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               busy, phase_end, tck_rise, step_done;
  logic [SW-1:0]      last_step;
  logic [LENW:0]      sh_amt;
  logic               len_bad;

  // The TCK engine only runs in scan states; RESET_TAP waits for TRST release.
  assign busy      = ((state_q == S_RESET_TAP) && !trst_q) ||
                     (state_q inside {S_SEL, S_SHIFT, S_UPD, S_RTI});
  assign phase_end = busy && (cnt_q == CW'(CLK_DIV));
  assign tck_rise  = phase_end && !tck_q;
  assign step_done = phase_end && tck_q;
  assign last_step = SW'(len_q) - SW'(1);
  assign sh_amt    = (LENW + 1)'(MAX_LEN) - {1'b0, len_q};
  assign len_bad   = (cmd_if.cmd_len == '0) || (cmd_if.cmd_len > LENW'(MAX_LEN));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_RESET_TAP;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      trst_q     <= 1'b1;
      cnt_q      <= '0;
      step_q     <= '0;
      is_ir_q    <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
      ret_rsp_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      trst_q     <= trst_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      is_ir_q    <= is_ir_d;
      len_q      <= len_d;
      data_q     <= data_d;
      ret_rsp_q  <= ret_rsp_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    trst_d     = trst_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    is_ir_d    = is_ir_q;
    len_d      = len_q;
    data_d     = data_q;
    ret_rsp_d  = ret_rsp_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    if (busy) begin
      cnt_d = phase_end ? '0 : cnt_q + CW'(1);
      if (phase_end) tck_d = ~tck_q;
      // TDO enters at the MSB; the finished scan is right-aligned in SHIFT.
      if (tck_rise && (state_q == S_SHIFT))
        rsp_data_d = {tgt_tdo_i, rsp_data_q[MAX_LEN-1:1]};
    end

    case (state_q)
      S_RESET_TAP: begin
        if (trst_q) begin
          trst_d = 1'b0;
        end else if (step_done) begin
          if (step_q == SW'(5)) begin
            state_d = ret_rsp_q ? S_RESP : S_IDLE;
            step_d  = '0;
            tms_d   = 1'b0;
          end else begin
            step_d = step_q + SW'(1);
            tms_d  = (step_q != SW'(4));
          end
        end
      end
      S_IDLE: begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
        if (tun_req_i) begin
          state_d = S_OWN_TUN;
        end else if (cmd_if.cmd_valid) begin
          len_d      = cmd_if.cmd_len;
          is_ir_d    = (cmd_if.cmd_type == 2'd0);
          data_d     = cmd_if.cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          step_d     = '0;
          cnt_d      = '0;
          case (cmd_if.cmd_type)
            2'd0, 2'd1: begin
              if (len_bad) begin
                state_d   = S_RESP;
                rsp_err_d = 1'b1;
              end else begin
                state_d = S_SEL;
                tms_d   = 1'b1;
              end
            end
            2'd2: begin
              state_d   = S_RESET_TAP;
              ret_rsp_d = 1'b1;
              tms_d     = 1'b1;
            end
            default: begin
              if (cmd_if.cmd_len == '0) begin
                state_d   = S_RESP;
                rsp_err_d = 1'b1;
              end else begin
                state_d = S_RTI;
              end
            end
          endcase
        end
      end
      S_SEL: begin
        if (step_done) begin
          if (step_q == (is_ir_q ? SW'(3) : SW'(2))) begin
            state_d = S_SHIFT;
            step_d  = '0;
            tms_d   = (len_q == LENW'(1));
            tdi_d   = data_q[0];
          end else begin
            step_d = step_q + SW'(1);
            tms_d  = is_ir_q && (step_q == SW'(0));
          end
        end
      end
      S_SHIFT: begin
        if (step_done) begin
          if (step_q == last_step) begin
            state_d    = S_UPD;
            step_d     = '0;
            tms_d      = 1'b1;
            tdi_d      = 1'b0;
            rsp_data_d = rsp_data_q >> sh_amt;
          end else begin
            step_d = step_q + SW'(1);
            data_d = data_q >> 1;
            tdi_d  = data_q[1];
            tms_d  = ((step_q + SW'(1)) == last_step);
          end
        end
      end
      S_UPD: begin
        if (step_done) begin
          tms_d = 1'b0;
          if (step_q == SW'(1)) begin
            state_d = S_RESP;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      S_RTI: begin
        if (step_done) begin
          if (step_q == last_step) begin
            state_d = S_RESP;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      S_RESP: begin
        if (cmd_if.rsp_ready) begin
          state_d   = S_IDLE;
          ret_rsp_d = 1'b0;
        end
      end
      S_OWN_TUN: begin
        // The tunnel may leave the TAP anywhere, so always re-reset it.
        if (!tun_req_i) begin
          state_d   = S_RESET_TAP;
          step_d    = '0;
          cnt_d     = '0;
          tck_d     = 1'b0;
          tms_d     = 1'b1;
          tdi_d     = 1'b0;
          ret_rsp_d = 1'b0;
        end
      end
      default: state_d = S_RESET_TAP;
    endcase
  end

  always_comb begin
    grant_tun_o      = (state_q == S_OWN_TUN);
    cmd_if.cmd_ready = (state_q == S_IDLE) && !tun_req_i;
    cmd_if.rsp_valid = (state_q == S_RESP);
    cmd_if.rsp_data  = rsp_data_q;
    cmd_if.rsp_err   = rsp_err_q;
    if (state_q == S_OWN_TUN) begin
      tgt_tck_o  = tun_tck_i;
      tgt_tms_o  = tun_tms_i;
      tgt_tdi_o  = tun_tdi_i;
      tgt_trst_o = tun_trst_i;
    end else begin
      tgt_tck_o  = tck_q;
      tgt_tms_o  = tms_q;
      tgt_tdi_o  = tdi_q;
      tgt_trst_o = trst_q;
    end
  end

endmodule

// File: doc/jtag_tgt_master.md
Name: jtag_tgt_master

Overview:
- Command-driven JTAG master that sequences the target TAP (TGT_TCK/TMS/TDI/TRST) from an on-chip command/response interface.
- Arbitrates the same target JTAG pins with the UJTAG tunnel path, which is the uj_jtag target-side output.
- Sits between the tunnel bridge and the RISC-V debug module TAP. It lets firmware or a test sequencer run IR/DR scans when the tunnel is idle.

Parameters:
- MAX_LEN, 32, maximum scan length in bits; sets CMD_DATA/RSP_DATA width.
- LENW, 6, width of CMD_LEN. Must satisfy 2^LENW > MAX_LEN.
- CLK_DIV, 1, TCK half-period is CLK_DIV+1 CLK cycles.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_TYPE  in  2  0=IR scan, 1=DR scan, 2=TAP reset, 3=run-test idle.
- CMD_LEN  in  LENW  scan bits (types 0/1) or idle TCK count (type 3).
- CMD_DATA  in  MAX_LEN  TDI bits, shifted LSB first.
- RSP_VALID  out  1  response valid; held until RSP_READY.
- RSP_READY  in  1  response accept.
- RSP_DATA  out  MAX_LEN  captured TDO bits, right-aligned; unused bits are 0.
- RSP_ERR  out  1  command rejected.
- TUN_REQ  in  1  tunnel requests the target port (level).
- TUN_TCK, TUN_TMS, TUN_TDI, TUN_TRST  in  1 each  tunnel-side JTAG signals.
- GRANT_TUN  out  1  tunnel owns the target pins.
- TGT_TDO  in  1  target TDO.
- TGT_TCK, TGT_TMS, TGT_TDI, TGT_TRST  out  1 each  target JTAG. TGT_TRST is active-high.

Behaviour:
- Reset values:
  - TGT_TCK=0, TGT_TMS=1, TGT_TDI=0, TGT_TRST=1.
  - CMD_READY=0, RSP_VALID=0, RSP_ERR=0, RSP_DATA=0, GRANT_TUN=0.
  - State=RESET_TAP.
  - TGT_TRST drops to 0 on the first CLK after RESETN rises.
- TCK step (master mode): one TCK period is 2*(CLK_DIV+1) CLK cycles.
  - At the start of the low phase, TMS and TDI are updated.
  - After CLK_DIV+1 cycles, TCK rises. TGT_TDO is sampled on the CLK edge where TCK rises.
  - TCK falls after CLK_DIV+1 more cycles.
- FSM states:
  - RESET_TAP: 5 steps TMS=1, then 1 step TMS=0, then IDLE. TAP ends in Run-Test/Idle.
  - IDLE: TCK held low, TMS=0.
    - If TUN_REQ=1, go to OWN_TUN. The tunnel has priority over pending commands, and CMD_READY=0.
    - Otherwise CMD_READY=1. Accepting a command decodes it.
  - Error decode: a scan with LEN=0 or LEN>MAX_LEN goes to RESP with RSP_ERR=1, RSP_DATA=0 and no TCK. This also applies to type 3 with LEN=0.
  - SEL: TMS sequence 1,0,0 for DR; 1,1,0,0 for IR. Ends in Shift-xR.
  - SHIFT: LEN steps.
    - TDI=CMD_DATA[i]; TDO captured into RSP_DATA[i].
    - TMS=0 except the final bit, which uses TMS=1 to reach Exit1.
  - UPD: TMS=1 (Update) then TMS=0 (Run-Test/Idle), then RESP.
  - RTI: LEN steps with TMS=0, then RESP.
  - Type 2: enter RESET_TAP, then RESP.
  - RESP: RSP_VALID=1 until RSP_READY. Then IDLE. No new command is accepted before the response is taken.
  - OWN_TUN: GRANT_TUN=1 and TGT_* = TUN_* combinationally. When TUN_REQ=0, go to RESET_TAP with GRANT_TUN=0.
- Total TCK counts: DR scan = LEN+5, IR scan = LEN+6.
- Grant changes only while master TCK is low and the FSM is in IDLE, OWN_TUN or RESET_TAP entry. TUN_REQ rising mid-command waits until the command completes and its response is accepted.
- TUN_REQ falling: master issues RESET_TAP before any command. The master never trusts the TAP state left by the tunnel.
- RESETN asserted mid-operation: all outputs return to their reset values immediately (asynchronously). An in-flight command is discarded and no response is produced.

Test Plan:
- Reset release, CLK_DIV=1 -> TGT_TRST 1→0, exactly 6 TCK pulses (TMS 1,1,1,1,1,0), 4 CLK each, then CMD_READY=1.
- DR scan with LEN=8, DATA=0xA5, TGT_TDO looped to TGT_TDI -> 13 TCK, TMS pattern 1,0,0,0×7,1,1,0, RSP_DATA=0x000000A5, RSP_ERR=0.
- IR scan with LEN=5, DATA=0x11, TGT_TDO=1 -> 11 TCK, TMS 1,1,0,0,0,0,0,0,1,1,0, RSP_DATA=0x1F.
- DR scan with LEN=0, and another with LEN=40 -> RSP_ERR=1, RSP_DATA=0, no TCK edge. Type 3 with LEN=3 -> 3 TCK with TMS=0, RSP_ERR=0.
- TUN_REQ=1 during a 32-bit DR scan -> scan finishes, response accepted, then GRANT_TUN=1 and TGT_TMS follows TUN_TMS. TUN_REQ=0 -> GRANT_TUN=0 and a 6-TCK reset sequence runs.
- RESETN pulsed low mid-SHIFT -> outputs go to reset values immediately, RSP_VALID never asserts, and the reset sequence reruns.
